// File: rtl/wb_regfile.sv
// Writeback-stage register file: fifteen 32-bit registers (R0-R14, R15 reads as zero),
// with write-through read bypass and a small FSM that holds the pipeline while load data
// is outstanding, giving up with a sticky error after TIMEOUT cycles.
module wb_regfile #(
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] SP_RESET = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_ir_wb,
   input  logic        i_wb_en,
   input  logic [3:0]  i_wb_addr,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_rvalid,
   input  logic [3:0]  i_rs1_addr,
   input  logic [3:0]  i_rs2_addr,
   output logic [31:0] o_rs1_data,
   output logic [31:0] o_rs2_data,
   output logic [31:0] o_sp,
   output logic        o_stall,
   output logic        o_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [3:0] SP_IDX = 4'd13;
   localparam logic [3:0] ZR_IDX = 4'd15;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         dest_q, dest_d;
   logic               err_q, err_d;
   logic [31:0]        regs_q [0:14];
   logic [31:0]        regs_d [0:14];

   logic               is_load;
   logic               wr_req;
   logic               wr_en;
   logic [3:0]         wr_addr;
   logic [31:0]        wr_data;
   logic               stall;

   assign is_load = (i_ir_wb[15:11] == 5'b01101) || (i_ir_wb[15:11] == 5'b01001);
   assign wr_en   = wr_req && (wr_addr != ZR_IDX);

   // Writeback control: decide write/stall this cycle and the next FSM state.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      dest_d  = dest_q;
      err_d   = err_q;
      wr_req  = 1'b0;
      wr_addr = i_wb_addr;
      wr_data = i_alu_result;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_wb_en) begin
               if (!is_load) begin
                  wr_req = 1'b1;
               end else if (i_mem_rvalid) begin
                  wr_req  = 1'b1;
                  wr_data = i_mem_rdata;
               end else begin
                  stall   = 1'b1;
                  state_d = ST_WAIT;
                  cnt_d   = '0;
                  dest_d  = i_wb_addr;
               end
            end
         end
         ST_WAIT: begin
            // Upstream is frozen, so only the latched destination matters here.
            wr_addr = dest_q;
            wr_data = i_mem_rdata;
            if (i_mem_rvalid) begin
               wr_req  = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next register-array contents: apply the single write port.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_addr] = wr_data;
   end

   // Read port 1: R15 is hard zero, otherwise bypass a same-cycle write.
   always_comb begin
      o_rs1_data = '0;
      if (i_rs1_addr != ZR_IDX) begin
         if (wr_en && (i_rs1_addr == wr_addr)) o_rs1_data = wr_data;
         else                                  o_rs1_data = regs_q[i_rs1_addr];
      end
   end

   // Read port 2: identical structure to port 1 so both always agree.
   always_comb begin
      o_rs2_data = '0;
      if (i_rs2_addr != ZR_IDX) begin
         if (wr_en && (i_rs2_addr == wr_addr)) o_rs2_data = wr_data;
         else                                  o_rs2_data = regs_q[i_rs2_addr];
      end
   end

   // State and register array; reset aborts any pending load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dest_q  <= '0;
         err_q   <= 1'b0;
         // NOTE: the array is architectural state with defined reset values, so it is reset like any flop.
         for (int i = 0; i < 15; i++) begin
            regs_q[i] <= (i == int'(SP_IDX)) ? SP_RESET : 32'h0;
         end
      end else begin
         // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dest_q  <= dest_d;
         err_q   <= err_d;
         regs_q  <= regs_d;
      end
   end

   // Stall is combinational so upstream holds in the very cycle the miss is seen.
   assign o_stall = stall & ~rst;
   assign o_err   = err_q;
   assign o_sp    = regs_q[SP_IDX];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: reset values, bypass, load hit/miss/timeout,
// R15 behaviour, SP visibility and reset during an outstanding load.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_ir_wb;
   logic        i_wb_en;
   logic [3:0]  i_wb_addr;
   logic [31:0] i_alu_result;
   logic [31:0] i_mem_rdata;
   logic        i_mem_rvalid;
   logic [3:0]  i_rs1_addr;
   logic [3:0]  i_rs2_addr;
   logic [31:0] o_rs1_data;
   logic [31:0] o_rs2_data;
   logic [31:0] o_sp;
   logic        o_stall;
   logic        o_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_regs [0:14];

   localparam logic [15:0] IR_ALU  = 16'h1C08;
   localparam logic [15:0] IR_LDR  = 16'h6808;
   localparam logic [15:0] IR_LDR2 = 16'h4800;

   wb_regfile #(.TIMEOUT(16), .SP_RESET(32'h0000_1000)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_ir_wb      (i_ir_wb),
      .i_wb_en      (i_wb_en),
      .i_wb_addr    (i_wb_addr),
      .i_alu_result (i_alu_result),
      .i_mem_rdata  (i_mem_rdata),
      .i_mem_rvalid (i_mem_rvalid),
      .i_rs1_addr   (i_rs1_addr),
      .i_rs2_addr   (i_rs2_addr),
      .o_rs1_data   (o_rs1_data),
      .o_rs2_data   (o_rs2_data),
      .o_sp         (o_sp),
      .o_stall      (o_stall),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_idle();
      i_ir_wb      = 16'h0000;
      i_wb_en      = 1'b0;
      i_wb_addr    = 4'd0;
      i_alu_result = 32'h0;
      i_mem_rdata  = 32'h0;
      i_mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      i_rs1_addr = 4'd0;
      i_rs2_addr = 4'd0;
      rst = 1'b1;
      // A write requested while reset is held must not land.
      i_ir_wb      = IR_ALU;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd1;
      i_alu_result = 32'h0BAD_0001;
      step();
      step();
      drive_idle();
      rst = 1'b0;
      i_rs1_addr = 4'd3;
      i_rs2_addr = 4'd13;
      #1;
      checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL reset_r3: got %h wanted %h", o_rs1_data, 32'h0); end
      checks++; if (o_rs2_data !== 32'h0000_1000) begin errors++; $display("FAIL reset_r13: got %h wanted %h", o_rs2_data, 32'h0000_1000); end
      checks++; if (o_sp !== 32'h0000_1000) begin errors++; $display("FAIL reset_sp: got %h wanted %h", o_sp, 32'h0000_1000); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b wanted 0", o_stall); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b wanted 0", o_err); end
      i_rs1_addr = 4'd1;
      #1;
      checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL reset_no_write_r1: got %h wanted %h", o_rs1_data, 32'h0); end
      for (int i = 0; i < 15; i++) exp_regs[i] = (i == 13) ? 32'h0000_1000 : 32'h0;
      @(negedge clk);
   endtask

   task automatic test_bypass();
      i_ir_wb      = IR_ALU;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd2;
      i_alu_result = 32'hA5A5_0001;
      i_rs1_addr   = 4'd2;
      i_rs2_addr   = 4'd2;
      #1;
      checks++; if (o_rs1_data !== 32'hA5A5_0001) begin errors++; $display("FAIL bypass_rs1: got %h wanted %h", o_rs1_data, 32'hA5A5_0001); end
      checks++; if (o_rs2_data !== 32'hA5A5_0001) begin errors++; $display("FAIL bypass_rs2_same: got %h wanted %h", o_rs2_data, 32'hA5A5_0001); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL bypass_stall: got %b wanted 0", o_stall); end
      step();
      drive_idle();
      #1;
      checks++; if (o_rs1_data !== 32'hA5A5_0001) begin errors++; $display("FAIL r2_stored: got %h wanted %h", o_rs1_data, 32'hA5A5_0001); end
      exp_regs[2] = 32'hA5A5_0001;
      // Load opcode with write enable low: no write and no stall.
      i_ir_wb    = IR_LDR;
      i_wb_addr  = 4'd5;
      i_mem_rdata = 32'h7777_7777;
      i_rs1_addr = 4'd5;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL wben0_stall: got %b wanted 0", o_stall); end
      step();
      drive_idle();
      #1;
      checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL wben0_no_write: got %h wanted %h", o_rs1_data, 32'h0); end
      @(negedge clk);
   endtask

   task automatic test_load_hit();
      i_ir_wb      = IR_LDR;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd6;
      i_alu_result = 32'h5555_5555;
      i_mem_rdata  = 32'hCAFE_F00D;
      i_mem_rvalid = 1'b1;
      i_rs1_addr   = 4'd6;
      #1;
      checks++; if (o_rs1_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_hit_bypass: got %h wanted %h", o_rs1_data, 32'hCAFE_F00D); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL load_hit_stall: got %b wanted 0", o_stall); end
      step();
      drive_idle();
      #1;
      checks++; if (o_rs1_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_hit_r6: got %h wanted %h", o_rs1_data, 32'hCAFE_F00D); end
      exp_regs[6] = 32'hCAFE_F00D;
      @(negedge clk);
   endtask

   task automatic test_load_wait();
      int stall_cnt;
      stall_cnt    = 0;
      i_ir_wb      = IR_LDR;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd4;
      i_mem_rvalid = 1'b0;
      i_rs1_addr   = 4'd4;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (o_stall === 1'b1) stall_cnt++;
         step();
         // Upstream pretends to present a different ALU write; it must be ignored.
         i_ir_wb      = IR_ALU;
         i_wb_addr    = 4'd7;
         i_alu_result = 32'hBEEF_0007;
      end
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h1234_5678;
      #1;
      checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL wait_stall_cycles: got %0d wanted %0d", stall_cnt, 3); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL wait_release_stall: got %b wanted 0", o_stall); end
      checks++; if (o_rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL wait_bypass_r4: got %h wanted %h", o_rs1_data, 32'h1234_5678); end
      step();
      drive_idle();
      #1;
      checks++; if (o_rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL wait_r4: got %h wanted %h", o_rs1_data, 32'h1234_5678); end
      i_rs1_addr = 4'd7;
      #1;
      checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL wait_r7_untouched: got %h wanted %h", o_rs1_data, 32'h0); end
      exp_regs[4] = 32'h1234_5678;
      @(negedge clk);
   endtask

   task automatic test_load_alt_opcode();
      i_ir_wb      = IR_LDR2;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd9;
      i_alu_result = 32'h0000_0BAD;
      i_mem_rvalid = 1'b0;
      #1;
      checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL alt_load_stall: got %b wanted 1", o_stall); end
      step();
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h9999_AAAA;
      step();
      drive_idle();
      i_rs1_addr = 4'd9;
      #1;
      checks++; if (o_rs1_data !== 32'h9999_AAAA) begin errors++; $display("FAIL alt_load_r9: got %h wanted %h", o_rs1_data, 32'h9999_AAAA); end
      exp_regs[9] = 32'h9999_AAAA;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int stall_cnt;
      int first_low;
      stall_cnt = 0;
      first_low = -1;
      i_ir_wb      = IR_ALU;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd8;
      i_alu_result = 32'h1111_2222;
      step();
      exp_regs[8]  = 32'h1111_2222;
      i_ir_wb      = IR_LDR;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'hDEAD_DEAD;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (o_stall === 1'b1) stall_cnt++;
         else if (first_low < 0) first_low = k;
         if (k == 15) begin
            checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL timeout_err_early: got %b wanted 0", o_err); end
         end
         step();
         if (k == 0) i_wb_en = 1'b0;
      end
      checks++; if (stall_cnt !== 16) begin errors++; $display("FAIL timeout_stall_cycles: got %0d wanted %0d", stall_cnt, 16); end
      checks++; if (first_low !== 16) begin errors++; $display("FAIL timeout_release_cycle: got %0d wanted %0d", first_low, 16); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b wanted 1", o_err); end
      drive_idle();
      i_rs1_addr = 4'd8;
      #1;
      checks++; if (o_rs1_data !== 32'h1111_2222) begin errors++; $display("FAIL timeout_r8_kept: got %h wanted %h", o_rs1_data, 32'h1111_2222); end
      @(negedge clk);
   endtask

   task automatic test_sp();
      i_ir_wb      = IR_ALU;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd13;
      i_alu_result = 32'h2000_0000;
      i_rs1_addr   = 4'd13;
      #1;
      checks++; if (o_sp !== 32'h0000_1000) begin errors++; $display("FAIL sp_not_bypassed: got %h wanted %h", o_sp, 32'h0000_1000); end
      checks++; if (o_rs1_data !== 32'h2000_0000) begin errors++; $display("FAIL sp_read_bypass: got %h wanted %h", o_rs1_data, 32'h2000_0000); end
      step();
      drive_idle();
      #1;
      checks++; if (o_sp !== 32'h2000_0000) begin errors++; $display("FAIL sp_updated: got %h wanted %h", o_sp, 32'h2000_0000); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b wanted 1", o_err); end
      exp_regs[13] = 32'h2000_0000;
      @(negedge clk);
   endtask

   task automatic test_r15();
      i_ir_wb      = IR_ALU;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd15;
      i_alu_result = 32'hFFFF_FFFF;
      i_rs1_addr   = 4'd15;
      i_rs2_addr   = 4'd15;
      #1;
      checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL r15_no_bypass: got %h wanted %h", o_rs1_data, 32'h0); end
      step();
      drive_idle();
      #1;
      checks++; if (o_rs2_data !== 32'h0) begin errors++; $display("FAIL r15_read: got %h wanted %h", o_rs2_data, 32'h0); end
      for (int i = 0; i < 15; i++) begin
         i_rs1_addr = 4'(i);
         #1;
         checks++; if (o_rs1_data !== exp_regs[i]) begin errors++; $display("FAIL r15_other_r%0d: got %h wanted %h", i, o_rs1_data, exp_regs[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      i_ir_wb      = IR_LDR;
      i_wb_en      = 1'b1;
      i_wb_addr    = 4'd2;
      i_mem_rvalid = 1'b0;
      step();
      i_wb_en = 1'b0;
      #1;
      checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL midwait_stall: got %b wanted 1", o_stall); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL midwait_stall_drop: got %b wanted 0", o_stall); end
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hDEAD_BEEF;
      step();
      step();
      drive_idle();
      rst = 1'b0;
      #1;
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL midwait_err_cleared: got %b wanted 0", o_err); end
      checks++; if (o_sp !== 32'h0000_1000) begin errors++; $display("FAIL midwait_sp: got %h wanted %h", o_sp, 32'h0000_1000); end
      for (int i = 0; i < 15; i++) exp_regs[i] = (i == 13) ? 32'h0000_1000 : 32'h0;
      for (int i = 0; i < 15; i++) begin
         i_rs1_addr = 4'(i);
         #1;
         checks++; if (o_rs1_data !== exp_regs[i]) begin errors++; $display("FAIL midwait_reset_r%0d: got %h wanted %h", i, o_rs1_data, exp_regs[i]); end
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_load_hit();
      test_load_wait();
      test_load_alt_opcode();
      test_timeout();
      test_sp();
      test_r15();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles waited for load data before abort.
REQ-002 SHALL have parameter SP_RESET, default 32'h0000_1000, meaning reset value of R13.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_ir_wb  input  16  instruction in writeback, from the MEM/WB control register.
REQ-006 SHALL have port i_wb_en  input  1  register write requested by the MEM/WB control register.
REQ-007 SHALL have port i_wb_addr  input  4  destination register index.
REQ-008 SHALL have port i_alu_result  input  32  non-load write data.
REQ-009 SHALL have port i_mem_rdata  input  32  load data.
REQ-010 SHALL have port i_mem_rvalid  input  1  i_mem_rdata valid this cycle.
REQ-011 SHALL have ports i_rs1_addr, i_rs2_addr  input  4 each  read port addresses.
REQ-012 SHALL have ports o_rs1_data, o_rs2_data  output  32 each  read port data.
REQ-013 SHALL have port o_sp  output  32  current R13 value.
REQ-014 SHALL have port o_stall  output  1  pipeline hold request to upstream stages.
REQ-015 SHALL have port o_err  output  1  sticky load-timeout flag.

Function
REQ-016 SHALL hold 15 writable 32-bit registers R0-R14; a write to index 15 SHALL be discarded, and a read of index 15 SHALL return 0.
REQ-017 SHALL classify a load as i_ir_wb[15:11] == 5'b01101 or 5'b01001; every other instruction is a non-load.
REQ-018 SHALL select write data: i_mem_rdata for a load, i_alu_result otherwise.
REQ-019 SHALL implement FSM states IDLE and WAIT with a wait counter of width clog2(TIMEOUT+1).
REQ-020 In IDLE, non-load with i_wb_en=1: write at this rising edge, remain in IDLE, o_stall=0.
REQ-021 In IDLE, load with i_wb_en=1 and i_mem_rvalid=1: write at this edge, remain in IDLE, o_stall=0.
REQ-022 In IDLE, load with i_wb_en=1 and i_mem_rvalid=0: no write, go to WAIT, clear counter, o_stall=1 combinationally in the same cycle.
REQ-023 In WAIT with i_mem_rvalid=1: write the latched destination with i_mem_rdata, go to IDLE, o_stall=0 in that cycle.
REQ-024 In WAIT with i_mem_rvalid=0: o_stall=1 and the counter increments.
REQ-025 In WAIT, when the counter reaches TIMEOUT-1 with rvalid still 0: set o_err=1 (sticky), abandon the write, return to IDLE, o_stall=0.
REQ-026 On entering WAIT, SHALL latch the destination address; inputs i_ir_wb, i_wb_addr and i_wb_en during WAIT SHALL be ignored (upstream is held by o_stall).
REQ-027 i_wb_en=0 SHALL never cause a write or stall, regardless of opcode.
REQ-028 Read ports SHALL be combinational with write-through bypass: if the read address equals the address being written at the next edge (index != 15), return the write data.
REQ-029 o_sp SHALL reflect R13 after the edge, and SHALL not be bypassed.
REQ-030 Both read ports reading the same address SHALL return identical data.

Reset
REQ-031 On rst=1, asynchronously: R0-R12 and R14 = 0, R13 = SP_RESET, FSM = IDLE, counter = 0, o_err = 0, o_stall = 0.
REQ-032 Reset asserted during WAIT SHALL abort the pending load with no register write.
REQ-033 The first write SHALL occur no earlier than the first rising edge after rst deasserts.

Verification
REQ-034 After reset, read R13 and R3 -> o_sp = 32'h0000_1000, o_rs1_data = 0, o_stall = 0, o_err = 0.
REQ-035 Non-load (i_ir_wb=16'h1C08) with wb_en=1, addr 2, alu=32'hA5A5_0001, rs1_addr=2 in the same cycle -> o_rs1_data = 32'hA5A5_0001 via bypass; R2 holds it next cycle.
REQ-036 LDR (i_ir_wb=16'h6808) with addr 4 and rvalid=0 for 3 cycles, then rvalid=1 with rdata=32'h1234_5678 -> o_stall=1 for exactly 3 cycles; R4 = 32'h1234_5678; addr changes during WAIT are ignored.
REQ-037 LDR with rvalid held 0 for 20 cycles -> o_stall=1 for 16 cycles then 0; o_err=1 and stays 1; destination register unchanged.
REQ-038 Write to index 15 with alu=32'hFFFF_FFFF, then read index 15 -> 0; no other register changes.
REQ-039 Assert rst mid-WAIT -> o_stall drops immediately; no write occurs; all registers return to reset values.
